// File: rtl/uart_text_pkg.sv
// Shared constants and types for the UART-to-text-buffer writer.
// Holds grid defaults, control-character codes, cursor commands and FSM states.
package uart_text_pkg;

  localparam int DEF_COLS       = 80;
  localparam int DEF_ROWS       = 30;
  localparam int DEF_ADDR_WIDTH = 12;

  localparam logic [7:0] CH_BS     = 8'h08;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_FF     = 8'h0C;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

  typedef enum logic [2:0] {
    CUR_NONE,
    CUR_INC,
    CUR_DEC,
    CUR_CR,
    CUR_LF,
    CUR_HOME
  } cursor_cmd_t;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_MIN) && (c <= PRINT_MAX);
  endfunction

endpackage

// File: rtl/text_cursor.sv
// Cursor position on the character grid: column, row and the matching linear address.
// The address is tracked incrementally so no multiplier is needed.
module text_cursor
  import uart_text_pkg::*;
#(
  parameter int COLS       = DEF_COLS,
  parameter int ROWS       = DEF_ROWS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  cursor_cmd_t           cmd,
  output logic [6:0]            col,
  output logic [4:0]            row,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam logic [6:0]            COL_LAST  = 7'(COLS - 1);
  localparam logic [4:0]            ROW_LAST  = 5'(ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_COLS = ADDR_WIDTH'(COLS);
  // Distance from row 0 to the last row, used when LF wraps to the top.
  localparam logic [ADDR_WIDTH-1:0] ADDR_WRAP = ADDR_WIDTH'((ROWS - 1) * COLS);

  // NOTE: state registers use non-blocking assignments so every register in the
  // block samples the pre-edge values, exactly like the flops they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else begin
      case (cmd)
        CUR_INC: begin
          if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST) begin
              row  <= '0;
              addr <= '0;
            end else begin
              row  <= row + 5'd1;
              addr <= addr + ADDR_ONE;
            end
          end else begin
            col  <= col + 7'd1;
            addr <= addr + ADDR_ONE;
          end
        end
        CUR_DEC: begin
          if (col != '0) begin
            col  <= col - 7'd1;
            addr <= addr - ADDR_ONE;
          end else if (row != '0) begin
            col  <= COL_LAST;
            row  <= row - 5'd1;
            addr <= addr - ADDR_ONE;
          end
        end
        CUR_CR: begin
          col  <= '0;
          addr <= addr - ADDR_WIDTH'(col);
        end
        CUR_LF: begin
          if (row == ROW_LAST) begin
            row  <= '0;
            addr <= addr - ADDR_WRAP;
          end else begin
            row  <= row + 5'd1;
            addr <= addr + ADDR_COLS;
          end
        end
        CUR_HOME: begin
          col  <= '0;
          row  <= '0;
          addr <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_text_writer.sv
// Turns UART bytes into VGA text-buffer writes: edge detect, 1-deep pending byte,
// control-code decode and a full-screen clear sweep on form feed.
module uart_text_writer
  import uart_text_pkg::*;
#(
  parameter int COLS       = DEF_COLS,
  parameter int ROWS       = DEF_ROWS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  wr_i,
  input  logic [7:0]            data_i,
  output logic                  buf_we_o,
  output logic [ADDR_WIDTH-1:0] buf_addr_o,
  output logic [7:0]            buf_data_o,
  output logic [6:0]            cursor_col_o,
  output logic [4:0]            cursor_row_o,
  output logic                  busy_o,
  output logic                  drop_o
);

  localparam logic [ADDR_WIDTH-1:0] CELL_LAST = ADDR_WIDTH'(COLS * ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  state_t                  state;
  logic                    wr_q;
  logic                    wr_edge;
  logic                    pend_valid;
  logic [7:0]              pend_data;
  logic                    decode;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  cursor_cmd_t             cmd;

  assign wr_edge = wr_i & ~wr_q;
  assign decode  = (state == ST_IDLE) && pend_valid;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    cmd = CUR_NONE;
    if (decode) begin
      if (is_printable(pend_data))  cmd = CUR_INC;
      else if (pend_data == CH_BS)  cmd = CUR_DEC;
      else if (pend_data == CH_CR)  cmd = CUR_CR;
      else if (pend_data == CH_LF)  cmd = CUR_LF;
    end else if (state == ST_CLEAR && clr_addr == CELL_LAST) begin
      cmd = CUR_HOME;
    end
  end

  text_cursor #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cursor (
    .clk   (clk_i),
    .rst_n (rstn_i),
    .cmd   (cmd),
    .col   (cursor_col_o),
    .row   (cursor_row_o),
    .addr  (cur_addr)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= ST_IDLE;
      wr_q       <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      clr_addr   <= '0;
      buf_we_o   <= 1'b0;
      buf_addr_o <= '0;
      buf_data_o <= '0;
      busy_o     <= 1'b0;
      drop_o     <= 1'b0;
    end else begin
      wr_q     <= wr_i;
      buf_we_o <= 1'b0;
      drop_o   <= wr_edge & pend_valid;

      // A new byte only loads an empty slot; the decode clear comes first so a
      // byte arriving as the old one is consumed is still counted as a drop.
      if (decode) pend_valid <= 1'b0;
      if (wr_edge && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_data  <= data_i;
      end

      case (state)
        ST_IDLE: begin
          busy_o <= 1'b0;
          if (pend_valid) begin
            if (is_printable(pend_data)) begin
              buf_we_o   <= 1'b1;
              buf_addr_o <= cur_addr;
              buf_data_o <= pend_data;
            end else if (pend_data == CH_BS) begin
              buf_we_o   <= 1'b1;
              buf_addr_o <= (cur_addr == '0) ? '0 : cur_addr - ADDR_ONE;
              buf_data_o <= CH_SPACE;
            end else if (pend_data == CH_FF) begin
              // The first sweep write goes out with the decode; the rest follow in CLEAR.
              buf_we_o   <= 1'b1;
              buf_addr_o <= '0;
              buf_data_o <= CH_SPACE;
              busy_o     <= 1'b1;
              clr_addr   <= ADDR_ONE;
              state      <= ST_CLEAR;
            end
          end
        end
        ST_CLEAR: begin
          buf_we_o   <= 1'b1;
          buf_addr_o <= clr_addr;
          buf_data_o <= CH_SPACE;
          busy_o     <= 1'b1;
          clr_addr   <= clr_addr + ADDR_ONE;
          if (clr_addr == CELL_LAST) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
